// File: rtl/uart_pkg.sv
// Shared state encoding and defaults for the UART transmit arbiter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    HOLD = 2'd2
  } arb_state_t;

  localparam int TIMEOUT_CYC_DEFAULT = 50000;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin pick: first valid index after last_grant, wrapping modulo NUM_REQ.
// Purely combinational; no backpressure.
module rr_picker
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IW-1:0]      last_grant,
  output logic [NUM_REQ-1:0] pick,
  output logic               any
);

  logic [IW-1:0] idx;

  always_comb begin
    pick = '0;
    any  = 1'b0;
    idx  = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = IW'((int'(last_grant) + off) % NUM_REQ);
      if (!any && valid[idx]) begin
        pick[idx] = 1'b1;
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Per-packet round-robin arbiter feeding bytes to a UART transmitter, one byte per two cycles.
// A byte is accepted only when the transmitter is not busy; an idle granted requester is aborted after TIMEOUT_CYC cycles.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic                 tx_busy,
  output logic [7:0]           tx_data,
  output logic                 new_tx_data,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 timeout_err
);

  localparam int            IW       = idx_width(NUM_REQ);
  localparam int            CW       = idx_width(TIMEOUT_CYC);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYC - 1);
  localparam logic [IW-1:0] LG_RESET = IW'(NUM_REQ - 1);

  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]      last_grant_q, last_grant_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               new_tx_data_q, new_tx_data_d;
  logic               timeout_err_q, timeout_err_d;
  logic               last_byte_q, last_byte_d;

  logic [NUM_REQ-1:0] pick;
  logic               pick_any;
  logic [IW-1:0]      gidx;
  logic [7:0]         g_byte;
  logic               g_valid;
  logic               accept;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_picker (
    .valid      (req_valid),
    .last_grant (last_grant_q),
    .pick       (pick),
    .any        (pick_any)
  );

  always_comb begin
    gidx   = '0;
    g_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        gidx   = IW'(i);
        g_byte = req_data[8*i +: 8];
      end
    end
  end

  assign g_valid   = |(req_valid & grant_q);
  assign accept    = (state_q == SEND) && g_valid && !tx_busy && !rst;
  assign req_ready = accept ? grant_q : '0;

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    cnt_d         = cnt_q;
    tx_data_d     = tx_data_q;
    new_tx_data_d = 1'b0;
    timeout_err_d = 1'b0;
    last_byte_d   = last_byte_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (accept) begin
          tx_data_d     = g_byte;
          new_tx_data_d = 1'b1;
          last_byte_d   = |(req_last & grant_q);
          cnt_d         = '0;
          state_d       = HOLD;
        end else if (!g_valid) begin
          // Only a silent requester ages; a busy transmitter never counts against it.
          if (cnt_q == CNT_MAX) begin
            timeout_err_d = 1'b1;
            grant_d       = '0;
            last_grant_d  = gidx;
            cnt_d         = '0;
            state_d       = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (last_byte_q) begin
          grant_d      = '0;
          last_grant_d = gidx;
          state_d      = IDLE;
        end else begin
          state_d = SEND;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      last_grant_q  <= LG_RESET;
      cnt_q         <= '0;
      tx_data_q     <= 8'h00;
      new_tx_data_q <= 1'b0;
      timeout_err_q <= 1'b0;
      last_byte_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      cnt_q         <= cnt_d;
      tx_data_q     <= tx_data_d;
      new_tx_data_q <= new_tx_data_d;
      timeout_err_q <= timeout_err_d;
      last_byte_q   <= last_byte_d;
    end
  end

  assign grant       = grant_q;
  assign tx_data     = tx_data_q;
  assign new_tx_data = new_tx_data_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: cycle vector table plus multi-cycle sequences.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NR-1:0] req_valid = '0;
  logic [8*NR-1:0] req_data = '0;
  logic [NR-1:0] req_last = '0;
  logic [NR-1:0] req_ready;
  logic          tx_busy = 1'b0;
  logic [7:0]    tx_data;
  logic          new_tx_data;
  logic [NR-1:0] grant;
  logic          timeout_err;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ     (NR),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_busy     (tx_busy),
    .tx_data     (tx_data),
    .new_tx_data (new_tx_data),
    .grant       (grant),
    .timeout_err (timeout_err)
  );

  typedef struct {
    logic          rst;
    logic [3:0]    vld;
    logic [31:0]   dat;
    logic [3:0]    lst;
    logic          busy;
    logic [3:0]    e_rdy;
    logic [3:0]    e_gnt;
    logic          e_ntx;
    logic [7:0]    e_txd;
    logic          e_terr;
  } vec_t;

  vec_t       tv[18];
  int         n_tests = 0;
  int         n_fail = 0;
  logic [3:0] rdy_s;
  string      msg = "Hello, World!\n";

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 1 ns after a rising edge; req_ready is sampled late in the cycle,
  // registered outputs 1 ns after the next edge.
  task automatic tick();
    #3;
    rdy_s = req_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; tx_busy = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  function automatic int oh_idx(input logic [3:0] v);
    int r = -1;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: time %0t exceeded limit 100000", $time);
    $fatal(1);
  end

  initial begin
    int bi, nstrobe, last_c, n, seen, stall_bad;
    int served[4];
    int nserved;

    //        rst vld   dat           lst   busy  rdy   gnt   ntx txd    terr
    tv[0]  = '{1, 4'h0, 32'h00000000, 4'h0, 0,    4'h0, 4'h0, 0,  8'h00, 0};
    tv[1]  = '{0, 4'h0, 32'h00000000, 4'h0, 0,    4'h0, 4'h0, 0,  8'h00, 0};
    tv[2]  = '{0, 4'h2, 32'h0000A100, 4'h0, 0,    4'h0, 4'h2, 0,  8'h00, 0};
    tv[3]  = '{0, 4'h2, 32'h0000A100, 4'h0, 0,    4'h2, 4'h2, 1,  8'hA1, 0};
    tv[4]  = '{0, 4'h2, 32'h0000A200, 4'h2, 0,    4'h0, 4'h2, 0,  8'hA1, 0};
    tv[5]  = '{0, 4'h2, 32'h0000A200, 4'h2, 0,    4'h2, 4'h2, 1,  8'hA2, 0};
    tv[6]  = '{0, 4'h0, 32'h00000000, 4'h0, 0,    4'h0, 4'h0, 0,  8'hA2, 0};
    tv[7]  = '{0, 4'hB, 32'hB300B1B0, 4'hB, 0,    4'h0, 4'h8, 0,  8'hA2, 0};
    tv[8]  = '{0, 4'hB, 32'hB300B1B0, 4'hB, 1,    4'h0, 4'h8, 0,  8'hA2, 0};
    tv[9]  = '{0, 4'hB, 32'hB300B1B0, 4'hB, 0,    4'h8, 4'h8, 1,  8'hB3, 0};
    tv[10] = '{0, 4'hB, 32'hB300B1B0, 4'hB, 0,    4'h0, 4'h0, 0,  8'hB3, 0};
    tv[11] = '{0, 4'hB, 32'hB300B1B0, 4'hB, 0,    4'h0, 4'h1, 0,  8'hB3, 0};
    tv[12] = '{0, 4'hB, 32'hB300B1B0, 4'hB, 0,    4'h1, 4'h1, 1,  8'hB0, 0};
    tv[13] = '{0, 4'hB, 32'hB300B1B0, 4'hB, 0,    4'h0, 4'h0, 0,  8'hB0, 0};
    tv[14] = '{0, 4'hB, 32'hB300B1B0, 4'hB, 0,    4'h0, 4'h2, 0,  8'hB0, 0};
    tv[15] = '{0, 4'h9, 32'hB300B1B0, 4'h9, 0,    4'h0, 4'h2, 0,  8'hB0, 0};
    tv[16] = '{0, 4'h2, 32'hB300B1B0, 4'h2, 0,    4'h2, 4'h2, 1,  8'hB1, 0};
    tv[17] = '{0, 4'h0, 32'h00000000, 4'h0, 0,    4'h0, 4'h0, 0,  8'hB1, 0};

    @(posedge clk);
    #1;
    for (int i = 0; i < 18; i++) begin
      rst = tv[i].rst; req_valid = tv[i].vld; req_data = tv[i].dat;
      req_last = tv[i].lst; tx_busy = tv[i].busy;
      tick();
      chk($sformatf("v%0d_rdy", i),  rdy_s,       tv[i].e_rdy);
      chk($sformatf("v%0d_gnt", i),  grant,       tv[i].e_gnt);
      chk($sformatf("v%0d_ntx", i),  new_tx_data, tv[i].e_ntx);
      chk($sformatf("v%0d_txd", i),  tx_data,     tv[i].e_txd);
      chk($sformatf("v%0d_terr", i), timeout_err, tv[i].e_terr);
    end

    // Single 14-byte packet from requester 1.
    do_reset();
    bi = 0; nstrobe = 0; last_c = -1;
    for (int c = 0; c < 100 && nstrobe < 14; c++) begin
      req_valid = (bi < 14) ? 4'b0010 : 4'b0000;
      req_data  = '0;
      req_data[15:8] = (bi < 14) ? msg[bi] : 8'h00;
      req_last  = (bi == 13) ? 4'b0010 : 4'b0000;
      tick();
      if (rdy_s != 4'b0000) begin
        chk("hello_rdy", rdy_s, 4'b0010);
        bi++;
      end
      if (new_tx_data) begin
        chk($sformatf("hello_byte%0d", nstrobe), tx_data, msg[nstrobe]);
        chk("hello_gnt", grant, 4'b0010);
        if (last_c >= 0) chk("hello_gap", c - last_c, 2);
        last_c = c;
        nstrobe++;
      end
    end
    chk("hello_count", nstrobe, 14);
    req_valid = '0; req_last = '0;
    tick();
    chk("hello_gnt_end", grant, 4'b0000);

    // Contention: 0, 2, 3 always valid with one-byte packets.
    do_reset();
    req_valid = 4'b1101; req_data = 32'h13121110; req_last = 4'b1101;
    nserved = 0;
    for (int c = 0; c < 40 && nserved < 4; c++) begin
      tick();
      if (rdy_s != 4'b0000) begin
        served[nserved] = oh_idx(rdy_s);
        nserved++;
      end
    end
    chk("cont_count", nserved, 4);
    chk("cont_first",  served[0], 0);
    chk("cont_second", served[1], 2);
    chk("cont_third",  served[2], 3);
    chk("cont_fourth", served[3], 0);

    // Busy stall mid-packet, then back-to-back packet from the same requester.
    do_reset();
    req_valid = 4'b0001; req_data = 32'h000000C0; req_last = '0;
    tick();
    chk("busy_gnt", grant, 4'b0001);
    tick();
    chk("busy_b0_ntx", new_tx_data, 1);
    chk("busy_b0_txd", tx_data, 8'hC0);
    tick();
    tx_busy = 1'b1; req_data = 32'h000000C1;
    stall_bad = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (rdy_s != 4'b0000 || new_tx_data || timeout_err) stall_bad++;
    end
    chk("busy_quiet", stall_bad, 0);
    chk("busy_gnt_held", grant, 4'b0001);
    tx_busy = 1'b0;
    tick();
    chk("busy_release_rdy", rdy_s, 4'b0001);
    chk("busy_release_ntx", new_tx_data, 1);
    chk("busy_release_txd", tx_data, 8'hC1);
    tick();
    req_data = 32'h000000C2; req_last = 4'b0001;
    tick();
    chk("busy_last_txd", tx_data, 8'hC2);
    tick();
    chk("busy_gnt_end", grant, 4'b0000);
    tick();
    chk("b2b_regrant", grant, 4'b0001);

    // Timeout: requester 2 goes silent while 3 waits.
    do_reset();
    req_valid = 4'b1100; req_data = 32'hE0D00000; req_last = 4'b1000;
    tick();
    chk("to_gnt", grant, 4'b0100);
    tick();
    chk("to_b0_txd", tx_data, 8'hD0);
    tick();
    req_valid = 4'b1000;
    n = 0; seen = 0;
    for (int c = 1; c <= 40 && seen == 0; c++) begin
      tick();
      if (timeout_err) begin
        seen = 1;
        n = c;
      end
    end
    chk("to_delay", n, 16);
    chk("to_gnt_clr", grant, 4'b0000);
    tick();
    chk("to_pulse_width", timeout_err, 0);
    chk("to_next_gnt", grant, 4'b1000);
    tick();
    chk("to_next_rdy", rdy_s, 4'b1000);
    chk("to_next_txd", tx_data, 8'hE0);

    // Reset mid-packet restores requester 0 priority.
    do_reset();
    req_valid = 4'b0001; req_data = 32'h00000055; req_last = 4'b0001;
    tick(); tick(); tick();
    req_valid = 4'b1000; req_last = '0; nstrobe = 0;
    for (int c = 0; c < 40 && nstrobe < 5; c++) begin
      req_data[31:24] = 8'(8'h30 + nstrobe);
      tick();
      if (new_tx_data) nstrobe++;
    end
    chk("rst_pre_strobes", nstrobe, 5);
    tick();
    rst = 1'b1;
    tick();
    chk("rst_no_rdy", rdy_s, 4'b0000);
    chk("rst_gnt", grant, 4'b0000);
    chk("rst_ntx", new_tx_data, 0);
    chk("rst_txd", tx_data, 8'h00);
    chk("rst_terr", timeout_err, 0);
    rst = 1'b0; req_valid = 4'b1001;
    tick();
    chk("rst_prio", grant, 4'b0001);
    chk("rst_no_strobe", new_tx_data, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
